// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: FSM state encoding, requester port indices and per-transaction byte count
// shared by dmem_arbiter and its grant logic.
package dmem_arb_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_TAIL = 2'd2,
        S_RESP = 2'd3
    } state_t;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;
    function automatic int nbytes_of(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter: two-way grant, round-robin on ties by default; defining DMEM_ARB_FIXED_PRIO_EN
// makes port 0 win every tie.
module dmem_rr_arbiter
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_valid
);
    logic w_pick_dbg;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_pick_dbg = i_req[PORT_DBG] & ~i_req[PORT_CPU];
`else
    assign w_pick_dbg = i_req[PORT_DBG] & (~i_req[PORT_CPU] | (i_last_grant == PORT_CPU));
`endif
    assign o_grant = {w_pick_dbg, i_req[PORT_CPU] & ~w_pick_dbg};
    assign o_valid = |i_req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a byte-wide 8192x8 data memory between the CPU (port 0) and a loader/debug
// agent (port 1), moving one little-endian doubleword per grant; DMEM_ARB_FIXED_PRIO_EN selects fixed CPU priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    localparam int NBYTES = nbytes_of(DATA_W);
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt, w_idx;
    logic              r_last, r_port, r_we, w_valid, w_cap;
    logic [1:0]        w_grant;
    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_wdata, r_rdata0, r_rdata1;

    dmem_rr_arbiter u_arb (
        .i_req       ({p1_req, p0_req}),
        .i_last_grant(r_last),
        .o_grant     (w_grant),
        .o_valid     (w_valid)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= S_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_valid ? S_XFER : S_IDLE;
            S_XFER:  w_next = (r_cnt != LAST) ? S_XFER : (r_we ? S_RESP : S_TAIL);
            S_TAIL:  w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory reads return a cycle late: XFER captures byte count-1, TAIL captures the final byte.
    assign w_idx = (r_state == S_TAIL) ? LAST : r_cnt - CW'(1);
    assign w_cap = ~r_we & ((r_state == S_XFER && r_cnt != '0) || r_state == S_TAIL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_last   <= PORT_DBG;
            r_port   <= PORT_CPU;
            r_we     <= 1'b0;
            r_base   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == S_IDLE && w_valid) begin
                r_port  <= w_grant[PORT_DBG];
                r_last  <= w_grant[PORT_DBG];
                r_we    <= w_grant[PORT_CPU] ? p0_we : p1_we;
                r_base  <= w_grant[PORT_CPU] ? p0_addr : p1_addr;
                r_wdata <= w_grant[PORT_CPU] ? p0_wdata : p1_wdata;
                r_cnt   <= '0;
            end
            if (r_state == S_XFER) r_cnt <= r_cnt + CW'(1);
            if (w_cap && r_port == PORT_CPU) r_rdata0[8*w_idx +: 8] <= mem_rdata;
            if (w_cap && r_port == PORT_DBG) r_rdata1[8*w_idx +: 8] <= mem_rdata;
        end
    end

    assign mem_addr  = (r_state == S_XFER) ? r_base + ADDR_W'(r_cnt) : '0;
    assign mem_we    = (r_state == S_XFER) & r_we;
    assign mem_wdata = mem_we ? r_wdata[8*r_cnt +: 8] : 8'h00;
    assign p0_ack    = (r_state == S_RESP) & (r_port == PORT_CPU);
    assign p1_ack    = (r_state == S_RESP) & (r_port == PORT_DBG);
    assign p0_rdata  = r_rdata0;
    assign p1_rdata  = r_rdata1;
    assign cpu_stall = p0_req & ~p0_ack;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a behavioural 8192x8 synchronous memory.
module tb_dmem_arbiter;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [12:0] p0_addr = '0, p1_addr = '0;
    logic [63:0] p0_wdata = '0, p1_wdata = '0;
    logic [63:0] p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack, cpu_stall, mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem [8192];

    localparam logic [63:0] W1 = 64'h8877665544332211;
    localparam logic [63:0] W2 = 64'h0807060504030201;
    localparam logic [63:0] W3 = 64'hA7A6A5A4A3A2A1A0;
    localparam logic [63:0] W4 = 64'h1357924680ACE0DF;
    localparam logic [63:0] W5 = 64'hCAFEBABEDEADBEEF;

    typedef struct {int port; int lat; logic we; logic [63:0] rd;} exp_t;
    exp_t q[$];
    int n_checks = 0, n_err = 0, n_we = 0, n_stall_bad = 0, drop_k = 0, n_acks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    dmem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int port, input logic we, input logic [12:0] addr, input logic [63:0] wd);
        if (port == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
        end
    endtask

    task automatic expect_ack(input int port, input int lat, input logic we, input logic [63:0] rd);
        exp_t e;
        e.port = port; e.lat = lat; e.we = we; e.rd = rd;
        q.push_back(e);
    endtask

    // k counts negedge samples after the edge at which requests were first visible (the grant edge when idle).
    task automatic run(input int max_k);
        exp_t e;
        int   k, port;
        k = 0; n_we = 0; n_stall_bad = 0;
        while (q.size() > 0 && k < max_k) begin
            @(negedge clk);
            k++;
            if (cpu_stall !== (p0_req & !(q[0].port == 0 && q[0].lat == k))) n_stall_bad++;
            if (mem_we) n_we++;
            if (k == drop_k) p0_req = 1'b0;
            if (p0_ack || p1_ack) begin
                e = q.pop_front();
                port = p1_ack ? 1 : 0;
                chk("ack_port", port, e.port);
                chk("ack_cycle", k, e.lat);
                if (!e.we) chk("ack_rdata", port ? p1_rdata : p0_rdata, e.rd);
                if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
            end
        end
        chk("pending_acks", q.size(), 0);
        chk("cpu_stall", n_stall_bad, 0);
        q.delete();
    endtask

    task automatic chk_mem(input string tag, input logic [12:0] addr, input logic [63:0] d);
        logic [12:0] a;
        for (int i = 0; i < 8; i++) begin
            a = addr + 13'(i);
            chk(tag, mem[a], d[8*i +: 8]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_p0_ack", p0_ack, 0);
        chk("rst_p1_ack", p1_ack, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        reset_n = 1'b1;

        // Tie after reset: CPU first, debug granted the cycle after CPU's RESP; debug write wraps.
        @(negedge clk);
        drive(0, 1'b1, 13'h010, W1);
        drive(1, 1'b1, 13'h1FFD, W2);
        expect_ack(0, 9, 1'b1, '0);
        expect_ack(1, 19, 1'b1, '0);
        run(40);
        chk("t1_we_count", n_we, 16);
        chk_mem("t1_p0_mem", 13'h010, W1);
        chk_mem("t1_p1_wrap_mem", 13'h1FFD, W2);

        @(negedge clk);
        drive(0, 1'b0, 13'h010, '0);
        expect_ack(0, 10, 1'b0, W1);
        run(20);
        chk("t2_we_count", n_we, 0);

        // CPU was served last, so round-robin gives the next tie to the debug port.
        @(negedge clk);
        drive(0, 1'b0, 13'h010, '0);
        drive(1, 1'b0, 13'h1FFD, '0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        expect_ack(0, 10, 1'b0, W1);
        expect_ack(1, 21, 1'b0, W2);
`else
        expect_ack(1, 10, 1'b0, W2);
        expect_ack(0, 21, 1'b0, W1);
`endif
        run(40);
        chk("t3_we_count", n_we, 0);

        for (int i = 0; i < 8; i++) mem[13'h100 + i] = 8'hEE;
        @(negedge clk);
        drive(0, 1'b1, 13'h100, W3);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_mem_we", mem_we, 0);
        chk("t4_rst_mem_addr", mem_addr, 0);
        chk("t4_rst_mem_wdata", mem_wdata, 0);
        chk("t4_rst_p0_ack", p0_ack, 0);
        chk("t4_rst_p0_rdata", p0_rdata, 0);
        chk("t4_rst_p1_rdata", p1_rdata, 0);
        p0_req = 1'b0;
        @(negedge clk);
        chk("t4_no_ack", p0_ack, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) chk("t4_written", mem[13'h100 + i], W3[8*i +: 8]);
        for (int i = 4; i < 8; i++) chk("t4_untouched", mem[13'h100 + i], 8'hEE);

        @(negedge clk);
        drive(0, 1'b1, 13'h200, W4);
        drive(1, 1'b0, 13'h010, '0);
        expect_ack(0, 9, 1'b1, '0);
        expect_ack(1, 20, 1'b0, W1);
        run(40);
        chk_mem("t4_after_rst_mem", 13'h200, W4);

        // Requester walks away two cycles into the write; the transfer still finishes.
        @(negedge clk);
        drive(0, 1'b1, 13'h300, W5);
        drop_k = 2;
        expect_ack(0, 9, 1'b1, '0);
        run(20);
        drop_k = 0;
        chk("t5_we_count", n_we, 8);
        n_acks = 0; n_we = 0;
        repeat (12) begin
            @(negedge clk);
            if (p0_ack || p1_ack) n_acks++;
            if (mem_we) n_we++;
        end
        chk("t5_idle_acks", n_acks, 0);
        chk("t5_idle_we", n_we, 0);
        chk_mem("t5_mem", 13'h300, W5);
        chk("t5_p1_rdata_held", p1_rdata, W1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Owns the byte-wide data-memory port (8192 x 8) and shares it between two requesters: port 0 = pipeline memory stage (CPU), port 1 = loader/debug agent.
- Each transaction moves one 64-bit doubleword, little-endian, byte-serially over the memory port.
- Drives a stall to the pipeline while a CPU request is pending or in service.

Parameters:
ADDR_W, 13, byte-address width (8192 bytes)
DATA_W, 64, transaction data width; must be a multiple of 8
NBYTES, DATA_W/8, bytes per transaction (derived, not overridable)

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
p0_req  in  1  CPU request, held high until p0_ack
p0_we  in  1  CPU 1=write, 0=read; sampled at grant
p0_addr  in  ADDR_W  CPU byte address of byte 0; sampled at grant
p0_wdata  in  DATA_W  CPU write data; sampled at grant
p0_rdata  out  DATA_W  CPU read data; valid in the p0_ack cycle
p0_ack  out  1  one-cycle completion pulse
p1_req, p1_we, p1_addr, p1_wdata, p1_rdata, p1_ack  same as p0_*, for the loader/debug port
cpu_stall  out  1  p0_req & ~p0_ack
mem_addr  out  ADDR_W  byte address to memory
mem_we  out  1  byte write strobe
mem_wdata  out  8  byte write data
mem_rdata  in  8  byte read data, synchronous: valid one cycle after address

Behaviour:
- Reset (async, reset_n=0): state=IDLE, byte count=0, last_grant=1, all outputs 0 (acks, mem_we, mem_addr, mem_wdata, rdata registers). Reset during a transaction aborts it at once; bytes already written stay written; no ack is issued.
- States: IDLE, XFER, TAIL, RESP.
- IDLE: when any req is high, grant one port. Round-robin: with both requesting, grant the port != last_grant. Latch we/addr/wdata, set last_grant, count=0, go to XFER. Grant decision and latch occur on the same edge.
- XFER: each cycle mem_addr = (base + count) mod 2^ADDR_W, so the address wraps from 8191 to 0. Write: mem_we=1, mem_wdata = wdata[8*count +: 8]. Read: mem_we=0, and the byte returned for count-1 is captured into rdata[8*(count-1) +: 8]. count increments. After count=NBYTES-1, a write goes to RESP and a read goes to TAIL.
- TAIL (read only): capture the last byte into rdata[8*(NBYTES-1) +: 8], mem_we=0, then go to RESP.
- RESP: pulse the granted port's ack for one cycle and hold its rdata stable through that cycle; return to IDLE. A new grant can occur no earlier than the cycle after RESP.
- Latency from grant edge to ack: write = NBYTES+1 cycles (9); read = NBYTES+2 cycles (10).
- The non-granted port's rdata holds its last value. mem_we is 0 in every state except write XFER.
- If req drops mid-transaction, the transaction still completes and ack is still pulsed; the requester ignores it.
- A request that arrives during a transaction waits; no preemption.

Optional Feature:
- DMEM_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins simultaneous requests; last_grant is still tracked but unused.
- Undefined: round-robin as above. Port 1 can starve CPU for at most one transaction.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_XFER=2'd1, S_TAIL=2'd2, S_RESP=2'd3
  - port index constants PORT_CPU=0, PORT_DBG=1
  - NBYTES derivation
- Sub-module dmem_rr_arbiter: 2-way grant logic (reqs, last_grant -> grant one-hot, valid), with the fixed-priority macro applied inside it only.

Test Plan:
- Reset, then p0 write addr=0x010, wdata=0x8877665544332211 -> mem_we high 8 cycles; bytes 0x11..0x88 at addresses 0x010..0x017; p0_ack 9 cycles after grant; cpu_stall high until the ack cycle.
- p0 read addr=0x010 after the above -> p0_rdata=0x8877665544332211 with p0_ack 10 cycles after grant; mem_we never high.
- p0 and p1 both request in the same cycle after reset -> p0 granted first and acked; p1 granted in the cycle after p0's RESP. Repeat both requests -> p1 granted first (round-robin). With DMEM_ARB_FIXED_PRIO_EN -> p0 granted first both times.
- p1 write addr=0x1FFD, wdata=0x0807060504030201 -> bytes land at 0x1FFD, 0x1FFE, 0x1FFF, 0x000, ..., 0x004; readback from 0x1FFD returns the same value.
- reset_n asserted in the 4th XFER cycle of a write -> outputs 0 immediately; no ack; 3 or 4 bytes written; the next request starts cleanly from IDLE with p0 winning ties.
- p0_req dropped 2 cycles after grant -> transaction completes, p0_ack pulses once, no further grant until req rises again.
